// File: rtl/keccak_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_pkg
//  Description : Shared Keccak sponge constants: state and lane geometry, mode
//                encoding, per-mode rate and digest word tables, and the
//                squeeze-side FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package keccak_pkg;

    // Sponge geometry
    localparam int unsigned STATE_W        = 1600;
    localparam int unsigned LANE_W         = 64;
    localparam int unsigned MAX_RATE_WORDS = 21;   // SHAKE128 has the widest rate

    // Mode encoding (2-bit)
    localparam logic [1:0] MODE_SHA3_512 = 2'd0;
    localparam logic [1:0] MODE_SHA3_256 = 2'd1;
    localparam logic [1:0] MODE_SHAKE128 = 2'd2;
    localparam logic [1:0] MODE_SHAKE256 = 2'd3;

    // Rate in 64-bit words, indexed by mode
    localparam logic [4:0] RATE_WORDS [4] = '{5'd9, 5'd17, 5'd21, 5'd17};

    // Fixed digest length in 64-bit words for the SHA3 modes, indexed by mode[0]
    localparam logic [4:0] DIGEST_WORDS [2] = '{5'd8, 5'd4};

    // Squeeze-side controller states
    typedef enum logic [1:0] {
        SQ_IDLE    = 2'd0,
        SQ_WAIT    = 2'd1,
        SQ_STREAM  = 2'd2,
        SQ_SQUEEZE = 2'd3
    } sq_state_t;

endpackage : keccak_pkg
`default_nettype wire

// File: rtl/keccak_rate_select.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_rate_select
//  Description : Purely combinational mode decoder. Maps the 2-bit Keccak
//                mode onto its rate (in 64-bit words), the digest-length cap
//                used by the fixed-output SHA3 modes, and an XOF flag.
//                Shared between the absorb-side padder and the squeezer.
//  Ports       : mode          in  2  mode encoding (see keccak_pkg)
//                rate_words    out 5  rate of the mode in 64-bit words
//                digest_words  out 5  digest cap in words (0 for XOF modes)
//                is_xof        out 1  mode produces arbitrary-length output
//  Revision    : 1.0 - initial release
// ============================================================================
module keccak_rate_select
    import keccak_pkg::*;
(
    input  logic [1:0] mode,
    output logic [4:0] rate_words,
    output logic [4:0] digest_words,
    output logic       is_xof
);

    // The two SHAKE encodings both have mode[1] set.
    assign is_xof = mode[1];

    always_comb begin
        rate_words   = RATE_WORDS[mode];
        digest_words = 5'd0;
        if (!mode[1]) begin
            digest_words = DIGEST_WORDS[mode[0]];
        end
    end

endmodule : keccak_rate_select
`default_nettype wire

// File: rtl/keccak_squeezer.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_squeezer
//  Description : Squeeze-side output stage of the Keccak sponge. Captures the
//                rate lanes of the permutation state, streams them as 64-bit
//                words over a valid/ready handshake and, for SHAKE jobs that
//                need more than one rate block, pulses squeeze to request a
//                further permutation before capturing again.
//  Parameters  : PERM_LATENCY  cycles from squeeze until state may be resampled
//                LEN_W         width of the output length request (words)
//  Ports       : clk           in  1     clock, rising edge
//                reset         in  1     asynchronous, active-low reset
//                mode          in  2     0 SHA3-512, 1 SHA3-256, 2/3 SHAKE128/256
//                start         in  1     begin a job (ignored unless idle)
//                out_len       in  LEN_W requested words (0 means 1)
//                state_in      in  1600  permutation state
//                state_ready   in  1     permutation state valid
//                squeeze       out 1     request another permutation (pulse)
//                dout          out 64    output word
//                dout_valid    out 1     dout valid
//                dout_ready    in  1     sink accepts dout
//                dout_last     out 1     final word of the job
//                busy          out 1     job in progress
//                done          out 1     pulse after the final handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module keccak_squeezer
    import keccak_pkg::*;
#(
    parameter int unsigned PERM_LATENCY = 24,
    parameter int unsigned LEN_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           mode,
    input  logic                 start,
    input  logic [LEN_W-1:0]     out_len,
    input  logic [STATE_W-1:0]   state_in,
    input  logic                 state_ready,
    output logic                 squeeze,
    output logic [LANE_W-1:0]    dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 dout_last,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned CNT_W  = $clog2(PERM_LATENCY + 1);
    localparam int unsigned TAIL_W = STATE_W - LANE_W * MAX_RATE_WORDS;

    // ------------------------------------------------------------------
    // Mode decode for the incoming request
    // ------------------------------------------------------------------
    logic [4:0]       w_rate_words;
    logic [4:0]       w_digest_words;
    logic             w_is_xof;
    logic [LEN_W-1:0] w_job_len;

    keccak_rate_select u_rate_select (
        .mode         (mode),
        .rate_words   (w_rate_words),
        .digest_words (w_digest_words),
        .is_xof       (w_is_xof)
    );

    // Zero-length requests still produce one word; SHA3 modes are clipped
    // to their digest length so they never outrun a single rate block.
    always_comb begin
        w_job_len = (out_len == '0) ? LEN_W'(1) : out_len;
        if (!w_is_xof && (w_job_len > LEN_W'(w_digest_words))) begin
            w_job_len = LEN_W'(w_digest_words);
        end
    end

    // ------------------------------------------------------------------
    // Rate lane slicing: lane k sits at the top of the state, MSB first
    // ------------------------------------------------------------------
    logic [LANE_W-1:0] w_lane [MAX_RATE_WORDS];

    for (genvar k = 0; k < MAX_RATE_WORDS; k++) begin : g_lane
        assign w_lane[k] = state_in[STATE_W - 1 - LANE_W * k -: LANE_W];
    end

    // Capacity lanes are never output.
    logic w_unused_capacity;
    assign w_unused_capacity = ^state_in[TAIL_W-1:0];

    // ------------------------------------------------------------------
    // Controller state
    // ------------------------------------------------------------------
    sq_state_t         r_state;
    logic [4:0]        r_rate;        // rate of the latched mode, in words
    logic [LEN_W-1:0]  r_rem;         // words still to emit in this job
    logic [4:0]        r_idx;         // words emitted from the current block
    logic [CNT_W-1:0]  r_cnt;         // permutation latency countdown
    logic [LANE_W-1:0] r_buf [MAX_RATE_WORDS];
    logic              r_dout_valid;
    logic              r_squeeze;
    logic              r_busy;
    logic              r_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= SQ_IDLE;
            r_rate       <= '0;
            r_rem        <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_dout_valid <= 1'b0;
            r_squeeze    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            for (int k = 0; k < MAX_RATE_WORDS; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            // Single-cycle pulses default low.
            r_done    <= 1'b0;
            r_squeeze <= 1'b0;

            case (r_state)
                SQ_IDLE: begin
                    // A start arriving while done is still showing belongs
                    // to the job that just ended and is dropped.
                    if (start && !r_done) begin
                        r_rate  <= w_rate_words;
                        r_rem   <= w_job_len;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SQ_WAIT;
                    end
                end

                SQ_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (state_ready) begin
                        for (int k = 0; k < MAX_RATE_WORDS; k++) begin
                            r_buf[k] <= w_lane[k];
                        end
                        r_idx        <= '0;
                        r_dout_valid <= 1'b1;
                        r_state      <= SQ_STREAM;
                    end
                end

                SQ_STREAM: begin
                    if (r_dout_valid && dout_ready) begin
                        for (int k = 0; k < MAX_RATE_WORDS - 1; k++) begin
                            r_buf[k] <= r_buf[k+1];
                        end
                        r_buf[MAX_RATE_WORDS-1] <= '0;
                        r_idx <= r_idx + 5'd1;
                        r_rem <= r_rem - LEN_W'(1);

                        if (r_rem == LEN_W'(1)) begin
                            r_dout_valid <= 1'b0;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_state      <= SQ_IDLE;
                        end else if ((r_idx + 5'd1) == r_rate) begin
                            // Block exhausted with output still owed:
                            // raise squeeze now so it is visible in the
                            // cycle right after the last handshake.
                            r_dout_valid <= 1'b0;
                            r_squeeze    <= 1'b1;
                            r_state      <= SQ_SQUEEZE;
                        end
                    end
                end

                SQ_SQUEEZE: begin
                    r_cnt   <= CNT_W'(PERM_LATENCY);
                    r_state <= SQ_WAIT;
                end

                default: begin
                    r_state <= SQ_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dout       = r_buf[0];
    assign dout_valid = r_dout_valid;
    assign dout_last  = r_dout_valid && (r_rem == LEN_W'(1));
    assign squeeze    = r_squeeze;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule : keccak_squeezer
`default_nettype wire

// File: tb/tb_keccak_squeezer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keccak_squeezer
//  Description : Directed self-checking bench for keccak_squeezer. Each task
//                drives one scenario and compares the observed words,
//                handshake timing, squeeze pulses and done against values
//                derived from a simple lane-pattern model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keccak_squeezer;

    localparam int PERM_LAT = 24;
    localparam int LW       = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     mode;
    logic           start;
    logic [LW-1:0]  out_len;
    logic [1599:0]  state_in;
    logic           state_ready;
    logic           squeeze;
    logic [63:0]    dout;
    logic           dout_valid;
    logic           dout_ready;
    logic           dout_last;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    keccak_squeezer #(
        .PERM_LATENCY (PERM_LAT),
        .LEN_W        (LW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .start       (start),
        .out_len     (out_len),
        .state_in    (state_in),
        .state_ready (state_ready),
        .squeeze     (squeeze),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout_last   (dout_last),
        .busy        (busy),
        .done        (done)
    );

    int checks = 0;
    int errors = 0;

    // Observation record filled by collect()
    logic [63:0] words[$];
    int          hs_cyc[$];
    int          sq_cyc[$];
    int          last_pos;
    int          n_last;
    int          done_cyc;
    int          first_valid;
    int          stall_err;
    logic        busy_at_done;

    // ------------------------------------------------------------------
    // Lane pattern model
    // ------------------------------------------------------------------
    function automatic logic [63:0] lane_val(input int seed, input int k);
        logic [15:0] s16, k16, mix;
        s16 = 16'(seed);
        k16 = 16'(k);
        mix = 16'(seed * 7 + k * 13);
        return {s16, 16'hA5C3, k16, mix};
    endfunction

    // Lane 0 is shifted in first so it ends up in the top 64 bits.
    function automatic logic [1599:0] make_state(input int seed);
        logic [1599:0] st;
        st = '0;
        for (int k = 0; k < 25; k++) begin
            st = {st[1535:0], lane_val(seed, k)};
        end
        return st;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one edge; returns 1 time unit after that edge.
    task automatic start_job(input logic [1:0] m, input logic [LW-1:0] len);
        mode    = m;
        out_len = len;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    // Runs the sink for up to max_cyc edges, recording handshakes. Cycle c
    // is the c-th edge after the call. On a squeeze pulse the state input
    // is replaced by next_state.
    task automatic collect(input int max_cyc, input bit rand_ready,
                           input logic [1599:0] next_state);
        logic [63:0] prev_dout;
        bit          prev_stall;
        words.delete();
        hs_cyc.delete();
        sq_cyc.delete();
        last_pos     = -1;
        n_last       = 0;
        done_cyc     = -1;
        first_valid  = -1;
        stall_err    = 0;
        busy_at_done = 1'b1;
        prev_stall   = 1'b0;
        prev_dout    = '0;
        for (int c = 1; c <= max_cyc; c++) begin
            dout_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (dout_valid === 1'b1 && dout_ready) begin
                if (dout_last === 1'b1) begin
                    n_last++;
                    last_pos = words.size();
                end
                words.push_back(dout);
                hs_cyc.push_back(c);
            end
            prev_stall = (dout_valid === 1'b1) && !dout_ready;
            prev_dout  = dout;
            step();
            if (prev_stall && (dout_valid !== 1'b1 || dout !== prev_dout)) stall_err++;
            if (squeeze === 1'b1) begin
                sq_cyc.push_back(c);
                state_in = next_state;
            end
            if (dout_valid === 1'b1 && first_valid < 0) first_valid = c;
            if (done === 1'b1) begin
                done_cyc     = c;
                busy_at_done = busy;
                break;
            end
        end
        dout_ready = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dout !== 64'h0)    begin errors++; $display("FAIL reset_dout got %h want 0", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dout_valid); end
        checks++; if (dout_last !== 1'b0)  begin errors++; $display("FAIL reset_last got %b want 0", dout_last); end
        checks++; if (squeeze !== 1'b0)    begin errors++; $display("FAIL reset_squeeze got %b want 0", squeeze); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got %b want 0", done); end
        reset = 1'b1;
        step();
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_sha3_256();
        logic [1599:0] s;
        logic [63:0]   got;
        s = make_state(1);
        state_in = s;
        start_job(2'd1, 16'd4);
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL s256_wait_valid got %b want 0", dout_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL s256_busy got %b want 1", busy); end
        collect(100, 1'b0, s);
        checks++; if (first_valid != 1) begin errors++; $display("FAIL s256_first_valid got %0d want 1", first_valid); end
        checks++; if (words.size() != 4) begin errors++; $display("FAIL s256_count got %0d want 4", words.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < words.size()) ? words[i] : 64'hx;
            checks++; if (got !== lane_val(1, i)) begin errors++; $display("FAIL s256_word%0d got %h want %h", i, got, lane_val(1, i)); end
        end
        checks++; if (hs_cyc.size() != 4 || hs_cyc[0] != 2 || hs_cyc[3] != 5) begin errors++; $display("FAIL s256_throughput got first/last hs %0d/%0d want 2/5", (hs_cyc.size() > 0) ? hs_cyc[0] : -1, (hs_cyc.size() > 3) ? hs_cyc[3] : -1); end
        checks++; if (n_last != 1 || last_pos != 3) begin errors++; $display("FAIL s256_last got n=%0d pos=%0d want n=1 pos=3", n_last, last_pos); end
        checks++; if (done_cyc != 5) begin errors++; $display("FAIL s256_done_cycle got %0d want 5", done_cyc); end
        checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL s256_busy_at_done got %b want 0", busy_at_done); end
        checks++; if (sq_cyc.size() != 0) begin errors++; $display("FAIL s256_squeeze got %0d pulses want 0", sq_cyc.size()); end
    endtask

    // Called while done from the previous job is still high.
    task automatic test_done_start_ignored();
        int viol;
        viol = 0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ign_done_present got %b want 1", done); end
        start_job(2'd2, 16'd5);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy got %b want 0", busy); end
        for (int i = 0; i < 4; i++) begin
            step();
            if (dout_valid !== 1'b0 || busy !== 1'b0) viol++;
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL ign_activity got %0d active cycles want 0", viol); end
    endtask

    task automatic test_sha3_512_cap();
        logic [1599:0] s;
        logic [63:0]   got;
        s = make_state(2);
        state_in = s;
        start_job(2'd0, 16'd20);
        collect(100, 1'b0, s);
        checks++; if (words.size() != 8) begin errors++; $display("FAIL s512_count got %0d want 8", words.size()); end
        for (int i = 0; i < 8; i++) begin
            got = (i < words.size()) ? words[i] : 64'hx;
            checks++; if (got !== lane_val(2, i)) begin errors++; $display("FAIL s512_word%0d got %h want %h", i, got, lane_val(2, i)); end
        end
        checks++; if (n_last != 1 || last_pos != 7) begin errors++; $display("FAIL s512_last got n=%0d pos=%0d want n=1 pos=7", n_last, last_pos); end
        checks++; if (done_cyc != 9) begin errors++; $display("FAIL s512_done_cycle got %0d want 9", done_cyc); end
        checks++; if (sq_cyc.size() != 0) begin errors++; $display("FAIL s512_squeeze got %0d pulses want 0", sq_cyc.size()); end
        step();
    endtask

    task automatic test_shake128_squeeze();
        logic [1599:0] sa, sb;
        logic [63:0]   got, exp;
        int            gap;
        sa = make_state(3);
        sb = make_state(4);
        state_in = sa;
        start_job(2'd2, 16'd25);
        collect(300, 1'b0, sb);
        checks++; if (words.size() != 25) begin errors++; $display("FAIL sh128_count got %0d want 25", words.size()); end
        for (int i = 0; i < 25; i++) begin
            got = (i < words.size()) ? words[i] : 64'hx;
            exp = (i < 21) ? lane_val(3, i) : lane_val(4, i - 21);
            checks++; if (got !== exp) begin errors++; $display("FAIL sh128_word%0d got %h want %h", i, got, exp); end
        end
        checks++; if (sq_cyc.size() != 1) begin errors++; $display("FAIL sh128_squeeze_pulses got %0d want 1", sq_cyc.size()); end
        checks++; if (sq_cyc.size() < 1 || hs_cyc.size() < 21 || sq_cyc[0] != hs_cyc[20]) begin errors++; $display("FAIL sh128_squeeze_cycle got %0d want %0d", (sq_cyc.size() > 0) ? sq_cyc[0] : -1, (hs_cyc.size() > 20) ? hs_cyc[20] : -1); end
        gap = (hs_cyc.size() > 21) ? hs_cyc[21] - hs_cyc[20] : -1;
        checks++; if (gap < PERM_LAT + 2) begin errors++; $display("FAIL sh128_gap got %0d want >= %0d", gap, PERM_LAT + 2); end
        checks++; if (n_last != 1 || last_pos != 24) begin errors++; $display("FAIL sh128_last got n=%0d pos=%0d want n=1 pos=24", n_last, last_pos); end
        checks++; if (done_cyc < 0) begin errors++; $display("FAIL sh128_done got %0d want seen", done_cyc); end
        step();
    endtask

    task automatic test_backpressure();
        logic [1599:0] s;
        logic [63:0]   got;
        s = make_state(5);
        state_in = s;
        start_job(2'd3, 16'd17);
        collect(400, 1'b1, s);
        checks++; if (words.size() != 17) begin errors++; $display("FAIL bp_count got %0d want 17", words.size()); end
        for (int i = 0; i < 17; i++) begin
            got = (i < words.size()) ? words[i] : 64'hx;
            checks++; if (got !== lane_val(5, i)) begin errors++; $display("FAIL bp_word%0d got %h want %h", i, got, lane_val(5, i)); end
        end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stable got %0d unstable stalls want 0", stall_err); end
        checks++; if (sq_cyc.size() != 0) begin errors++; $display("FAIL bp_squeeze got %0d pulses want 0", sq_cyc.size()); end
        checks++; if (n_last != 1 || last_pos != 16) begin errors++; $display("FAIL bp_last got n=%0d pos=%0d want n=1 pos=16", n_last, last_pos); end
        checks++; if (done_cyc < 0) begin errors++; $display("FAIL bp_done got %0d want seen", done_cyc); end
        step();
    endtask

    task automatic test_zero_len();
        logic [1599:0] s;
        logic [63:0]   got;
        s = make_state(6);
        state_in = s;
        start_job(2'd2, 16'd0);
        collect(100, 1'b0, s);
        checks++; if (words.size() != 1) begin errors++; $display("FAIL zero_count got %0d want 1", words.size()); end
        got = (words.size() > 0) ? words[0] : 64'hx;
        checks++; if (got !== lane_val(6, 0)) begin errors++; $display("FAIL zero_word got %h want %h", got, lane_val(6, 0)); end
        checks++; if (n_last != 1 || last_pos != 0) begin errors++; $display("FAIL zero_last got n=%0d pos=%0d want n=1 pos=0", n_last, last_pos); end
        checks++; if (done_cyc != 2) begin errors++; $display("FAIL zero_done_cycle got %0d want 2", done_cyc); end
        step();
    endtask

    task automatic test_state_not_ready();
        logic [1599:0] s;
        logic [63:0]   got;
        int            viol;
        s = make_state(7);
        state_in    = s;
        state_ready = 1'b0;
        viol = 0;
        start_job(2'd2, 16'd3);
        for (int i = 0; i < 40; i++) begin
            step();
            if (dout_valid !== 1'b0) viol++;
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL nr_valid_early got %0d cycles want 0", viol); end
        state_ready = 1'b1;
        step();
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL nr_valid_after got %b want 1", dout_valid); end
        checks++; if (dout !== lane_val(7, 0)) begin errors++; $display("FAIL nr_first_word got %h want %h", dout, lane_val(7, 0)); end
        collect(100, 1'b0, s);
        checks++; if (words.size() != 3) begin errors++; $display("FAIL nr_count got %0d want 3", words.size()); end
        got = (words.size() > 2) ? words[2] : 64'hx;
        checks++; if (got !== lane_val(7, 2)) begin errors++; $display("FAIL nr_word2 got %h want %h", got, lane_val(7, 2)); end
        step();
    endtask

    task automatic test_reset_mid_job();
        logic [1599:0] s, s2;
        logic [63:0]   got;
        int            viol;
        s  = make_state(8);
        s2 = make_state(9);
        state_in = s;
        start_job(2'd2, 16'd30);
        repeat (10) step();
        checks++; if (dout_valid !== 1'b1 || dout !== lane_val(8, 9)) begin errors++; $display("FAIL rst_word10 got v=%b %h want v=1 %h", dout_valid, dout, lane_val(8, 9)); end
        reset = 1'b0;
        #1;
        checks++; if ({dout_valid, dout_last, squeeze, busy, done} !== 5'b0 || dout !== 64'h0)
            begin errors++; $display("FAIL rst_outputs got v%b l%b s%b b%b d%b dout=%h want all 0", dout_valid, dout_last, squeeze, busy, done, dout); end
        repeat (2) step();
        reset = 1'b1;
        viol = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (squeeze !== 1'b0 || busy !== 1'b0 || dout_valid !== 1'b0) viol++;
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL rst_quiet got %0d active cycles want 0", viol); end
        state_in = s2;
        start_job(2'd2, 16'd3);
        collect(100, 1'b0, s2);
        checks++; if (words.size() != 3) begin errors++; $display("FAIL rst_fresh_count got %0d want 3", words.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < words.size()) ? words[i] : 64'hx;
            checks++; if (got !== lane_val(9, i)) begin errors++; $display("FAIL rst_fresh_word%0d got %h want %h", i, got, lane_val(9, i)); end
        end
        checks++; if (done_cyc != 4) begin errors++; $display("FAIL rst_fresh_done got %0d want 4", done_cyc); end
    endtask

    // ------------------------------------------------------------------
    // Sequencer and watchdog
    // ------------------------------------------------------------------
    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        mode        = 2'd0;
        out_len     = '0;
        state_in    = '0;
        state_ready = 1'b1;
        dout_ready  = 1'b1;

        test_reset();
        test_sha3_256();
        test_done_start_ignored();
        test_sha3_512_cap();
        test_shake128_squeeze();
        test_backpressure();
        test_zero_len();
        test_state_not_ready();
        test_reset_mid_job();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_keccak_squeezer
`default_nettype wire
